pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges the hazard requests from ID (branch-operand bubble, load-use bubble, HI/LO and mult/div structural hazards) with control redirects into one set of per-stage write-enable and flush controls.
- Owns the multi-cycle mult/div occupancy counter and the stall/flush performance counters.
- Sits between the ID-stage hazard detectors and the PC, IF/ID and ID/EX pipeline registers.

Parameters:
- MD_LATENCY, 32: cycles the mult/div unit is busy after issue; legal range 1..64.
- DELAY_SLOT, 1: 1 = branch delay slot architected, so there is no IF/ID squash on redirect. 0 = squash the fetched instruction on redirect.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- branchbubble  in  1  ID branch/jr operand not yet forwardable.
- loaduse_bubble  in  1  ID source depends on a load in EX.
- id_md  in  1  ID holds mult/multu/div/divu.
- id_mfhilo  in  1  ID holds mfhi/mflo/mthi/mtlo.
- id_redirect  in  1  ID resolved taken branch, j, jal, jr or jalr.
- ex_md_start  in  1  mult/div instruction entering EX this cycle.
- pc_wr  out  1  PC register write enable.
- ifid_wr  out  1  IF/ID register write enable.
- ifid_flush  out  1  zero the IF/ID register.
- idex_flush  out  1  insert a bubble into ID/EX.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- md_err  out  1  sticky flag: ex_md_start asserted while busy.
- stall_cycles  out  CNT_W  count of cycles with stall asserted.
- flush_count  out  CNT_W  count of cycles with ifid_flush asserted.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state is cleared at the rising edge of clk while rst=1.
- Reset values: md_busy=0, md_cnt=0, md_done=0, md_err=0, stall_cycles=0, flush_count=0.
- While rst=1, the combinational outputs are forced: pc_wr=0, ifid_wr=0, ifid_flush=1, idex_flush=1.
- Internal stall term:
  - stall = branchbubble | loaduse_bubble | (md_busy & (id_md | id_mfhilo)).
  - It is combinational, with zero-cycle latency to the outputs.
- When stall=1: pc_wr=0, ifid_wr=0, idex_flush=1, ifid_flush=0.
  - A redirect is ignored while stalled; it is re-evaluated after the stall clears, because the ID instruction is held.
- When stall=0 and id_redirect=1: pc_wr=1, ifid_wr=1, idex_flush=0, and ifid_flush=~DELAY_SLOT.
- Otherwise: pc_wr=1, ifid_wr=1, ifid_flush=0, idex_flush=0.
- Mult/div state machine, states IDLE and BUSY; md_busy = (state == BUSY). Counter width is clog2(MD_LATENCY+1).
  - IDLE, ex_md_start=1: go to BUSY and load md_cnt = MD_LATENCY-1.
  - BUSY, md_cnt>0: decrement md_cnt.
  - BUSY, md_cnt==0: go to IDLE. md_done is a registered pulse, high during this final BUSY cycle.
  - MD_LATENCY=1: BUSY lasts exactly one cycle, with md_done high in that cycle.
  - ex_md_start while in BUSY: the start is ignored (the counter is not reloaded) and md_err is set. md_err stays set until reset.
  - A same-cycle ex_md_start on the final BUSY cycle (md_cnt==0) is also an error. There is no back-to-back chaining, because ID stalls id_md while busy.
- Performance counters:
  - stall_cycles increments on every non-reset cycle with stall=1.
  - flush_count increments on every non-reset cycle with ifid_flush=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation: a reset during BUSY returns to IDLE with md_cnt=0 in the next cycle; no md_done pulse is produced.

Decomposition:
- Shared package pipe_pkg holds:
  - the MD_LATENCY default;
  - constants MD_IDLE and MD_BUSY;
  - the per-stage control-bundle bit positions (pc_wr, ifid_wr, ifid_flush, idex_flush) reused by the top-level wiring.
- One natural sub-module: md_occupancy, containing the IDLE/BUSY state machine, md_cnt, md_done and md_err.
- The stall/flush merge logic and the performance counters stay in pipe_stall_ctrl.

Test Plan:
- Reset: hold rst for 3 cycles with random inputs -> pc_wr=0, ifid_flush=1, idex_flush=1; after release, md_busy=0, md_err=0, stall_cycles=0, flush_count=0.
- Branch bubble: branchbubble=1 for 2 cycles with id_redirect=1 -> pc_wr=0, ifid_wr=0, idex_flush=1 for both cycles. Then branchbubble=0 -> ifid_flush=0 (DELAY_SLOT=1), or 1 (DELAY_SLOT=0). stall_cycles=2.
- Mult/div occupancy, MD_LATENCY=4: ex_md_start pulse at cycle 10 -> md_busy high for cycles 11-14 and md_done at cycle 14. Assert id_mfhilo over cycles 11-16 -> stall in cycles 11-14 only.
- Illegal restart: ex_md_start at cycles 10 and 12, MD_LATENCY=4 -> busy still ends at cycle 14, md_err=1 from cycle 13 onward.
- MD_LATENCY=1 plus reset mid-busy: single-cycle BUSY with md_done in the same cycle. Separately, with MD_LATENCY=32, assert rst at busy cycle 5 -> md_busy=0 next cycle and no md_done pulse.
- Counter wrap: CNT_W=4, hold loaduse_bubble=1 for 17 cycles -> stall_cycles=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stall/flush sequencer and its mult/div tracker.
package pipe_pkg;

    localparam int MD_LATENCY_DEFAULT = 32;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam int CTL_PC_WR      = 0;
    localparam int CTL_IFID_WR    = 1;
    localparam int CTL_IFID_FLUSH = 2;
    localparam int CTL_IDEX_FLUSH = 3;
    localparam int CTL_W          = 4;

    typedef logic [CTL_W-1:0] ctl_t;

endpackage

// File: rtl/md_occupancy.sv
// Tracks how long the multi-cycle mult/div unit stays occupied after an issue,
// pulses md_done on the last busy cycle and latches any illegal restart.
module md_occupancy
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_md_start,
    output logic md_busy,
    output logic md_done,
    output logic md_err
);

    localparam int CW = $clog2(MD_LATENCY + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Next-state: load on issue from IDLE, count down while BUSY; done is precomputed so it is registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            MD_IDLE: begin
                if (ex_md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = LOAD_VAL;
                    done_d  = (LOAD_VAL == '0);
                end
            end
            default: begin
                if (ex_md_start) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    done_d = (cnt_q == CW'(1));
                end
            end
        endcase
    end

    // State registers with synchronous clear; a reset mid-busy drops straight to IDLE without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = done_q;
    assign md_err  = err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges ID hazard requests and redirects into
// PC / IF/ID / ID/EX controls, and keeps stall and flush performance counters.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter bit DELAY_SLOT = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchbubble,
    input  logic             loaduse_bubble,
    input  logic             id_md,
    input  logic             id_mfhilo,
    input  logic             id_redirect,
    input  logic             ex_md_start,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic             stall;
    ctl_t             ctl;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    md_occupancy #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_occupancy (
        .clk         (clk),
        .rst         (rst),
        .ex_md_start (ex_md_start),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_err      (md_err)
    );

    assign stall = branchbubble | loaduse_bubble | (md_busy & (id_md | id_mfhilo));

    // Control merge: reset freezes the front end, a stall holds PC and IF/ID while bubbling ID/EX,
    // and a redirect is only honoured once the held ID instruction is free to proceed.
    always_comb begin
        ctl = '0;
        if (rst) begin
            ctl[CTL_IFID_FLUSH] = 1'b1;
            ctl[CTL_IDEX_FLUSH] = 1'b1;
        end else if (stall) begin
            ctl[CTL_IDEX_FLUSH] = 1'b1;
        end else begin
            ctl[CTL_PC_WR]      = 1'b1;
            ctl[CTL_IFID_WR]    = 1'b1;
            ctl[CTL_IFID_FLUSH] = id_redirect & ~DELAY_SLOT;
        end
    end

    assign pc_wr      = ctl[CTL_PC_WR];
    assign ifid_wr    = ctl[CTL_IFID_WR];
    assign ifid_flush = ctl[CTL_IFID_FLUSH];
    assign idex_flush = ctl[CTL_IDEX_FLUSH];

    // Counter increments; both wrap naturally at the counter width.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (ctl[CTL_IFID_FLUSH]) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Counter registers; reset cycles are never counted because the clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench: three configurations of pipe_stall_ctrl share one stimulus
// stream; a countdown reference model predicts every output cycle by cycle.
module tb_pipe_stall_ctrl;

    typedef struct packed {
        logic        pcWr;
        logic        ifidWr;
        logic        ifidFlush;
        logic        idexFlush;
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] stallCnt;
        logic [31:0] flushCnt;
    } exp_t;

    localparam int NDUT = 3;
    localparam int LAT_P [NDUT] = '{4, 1, 32};
    localparam int DS_P  [NDUT] = '{1, 0, 1};
    localparam int CW_P  [NDUT] = '{4, 8, 32};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic branchbubble = 1'b0, loaduse_bubble = 1'b0, id_md = 1'b0;
    logic id_mfhilo = 1'b0, id_redirect = 1'b0, ex_md_start = 1'b0;

    logic        pcWrW [NDUT], ifidWrW [NDUT], ifidFlushW [NDUT], idexFlushW [NDUT];
    logic        busyW [NDUT], doneW [NDUT], errW [NDUT];
    logic [3:0]  stallA, flushA;
    logic [7:0]  stallB, flushB;
    logic [31:0] stallC, flushC;

    exp_t expQ [NDUT][$];

    int mdlRem   [NDUT];
    bit mdlErr   [NDUT];
    int unsigned mdlStall [NDUT];
    int unsigned mdlFlush [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_LATENCY(4), .DELAY_SLOT(1'b1), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .branchbubble(branchbubble), .loaduse_bubble(loaduse_bubble),
        .id_md(id_md), .id_mfhilo(id_mfhilo), .id_redirect(id_redirect), .ex_md_start(ex_md_start),
        .pc_wr(pcWrW[0]), .ifid_wr(ifidWrW[0]), .ifid_flush(ifidFlushW[0]), .idex_flush(idexFlushW[0]),
        .md_busy(busyW[0]), .md_done(doneW[0]), .md_err(errW[0]),
        .stall_cycles(stallA), .flush_count(flushA));

    pipe_stall_ctrl #(.MD_LATENCY(1), .DELAY_SLOT(1'b0), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .branchbubble(branchbubble), .loaduse_bubble(loaduse_bubble),
        .id_md(id_md), .id_mfhilo(id_mfhilo), .id_redirect(id_redirect), .ex_md_start(ex_md_start),
        .pc_wr(pcWrW[1]), .ifid_wr(ifidWrW[1]), .ifid_flush(ifidFlushW[1]), .idex_flush(idexFlushW[1]),
        .md_busy(busyW[1]), .md_done(doneW[1]), .md_err(errW[1]),
        .stall_cycles(stallB), .flush_count(flushB));

    pipe_stall_ctrl #(.MD_LATENCY(32), .DELAY_SLOT(1'b1), .CNT_W(32)) dutC (
        .clk(clk), .rst(rst), .branchbubble(branchbubble), .loaduse_bubble(loaduse_bubble),
        .id_md(id_md), .id_mfhilo(id_mfhilo), .id_redirect(id_redirect), .ex_md_start(ex_md_start),
        .pc_wr(pcWrW[2]), .ifid_wr(ifidWrW[2]), .ifid_flush(ifidFlushW[2]), .idex_flush(idexFlushW[2]),
        .md_busy(busyW[2]), .md_done(doneW[2]), .md_err(errW[2]),
        .stall_cycles(stallC), .flush_count(flushC));

    function automatic logic [31:0] stallOf(int k);
        case (k)
            0:       return {28'd0, stallA};
            1:       return {24'd0, stallB};
            default: return stallC;
        endcase
    endfunction

    function automatic logic [31:0] flushOf(int k);
        case (k)
            0:       return {28'd0, flushA};
            1:       return {24'd0, flushB};
            default: return flushC;
        endcase
    endfunction

    task automatic checkOutput(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL dut%0d %s at %0t: got %0h expected %0h", k, name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, predict the outputs for that cycle,
    // then advance the reference model to the state it will hold after the next edge.
    task automatic applyStimulus(input logic r, input logic bb, input logic lu, input logic md,
                                 input logic mfh, input logic redir, input logic start);
        #1;
        rst = r; branchbubble = bb; loaduse_bubble = lu; id_md = md;
        id_mfhilo = mfh; id_redirect = redir; ex_md_start = start;
        for (int k = 0; k < NDUT; k++) begin
            exp_t e;
            logic stl;
            int unsigned mask;
            mask = (CW_P[k] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW_P[k]) - 32'd1);
            e.busy     = (mdlRem[k] > 0);
            e.done     = (mdlRem[k] == 1);
            e.err      = mdlErr[k];
            e.stallCnt = mdlStall[k];
            e.flushCnt = mdlFlush[k];
            stl = bb | lu | (e.busy & (md | mfh));
            if (r) begin
                e.pcWr = 0; e.ifidWr = 0; e.ifidFlush = 1; e.idexFlush = 1;
            end else if (stl) begin
                e.pcWr = 0; e.ifidWr = 0; e.ifidFlush = 0; e.idexFlush = 1;
            end else begin
                e.pcWr = 1; e.ifidWr = 1; e.idexFlush = 0;
                e.ifidFlush = redir && (DS_P[k] == 0);
            end
            expQ[k].push_back(e);
            if (r) begin
                mdlRem[k] = 0; mdlErr[k] = 0; mdlStall[k] = 0; mdlFlush[k] = 0;
            end else begin
                if (stl)         mdlStall[k] = (mdlStall[k] + 1) & mask;
                if (e.ifidFlush) mdlFlush[k] = (mdlFlush[k] + 1) & mask;
                if (mdlRem[k] > 0) begin
                    if (start) mdlErr[k] = 1;
                    mdlRem[k]--;
                end else if (start) begin
                    mdlRem[k] = LAT_P[k];
                end
            end
        end
        @(posedge clk);
    endtask

    // Monitor: every falling edge the DUTs present a full output set; pop the prediction and compare.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (expQ[k].size() > 0) begin
                exp_t e;
                e = expQ[k].pop_front();
                checkOutput(k, "pc_wr",        {31'd0, pcWrW[k]},      {31'd0, e.pcWr});
                checkOutput(k, "ifid_wr",      {31'd0, ifidWrW[k]},    {31'd0, e.ifidWr});
                checkOutput(k, "ifid_flush",   {31'd0, ifidFlushW[k]}, {31'd0, e.ifidFlush});
                checkOutput(k, "idex_flush",   {31'd0, idexFlushW[k]}, {31'd0, e.idexFlush});
                checkOutput(k, "md_busy",      {31'd0, busyW[k]},      {31'd0, e.busy});
                checkOutput(k, "md_done",      {31'd0, doneW[k]},      {31'd0, e.done});
                checkOutput(k, "md_err",       {31'd0, errW[k]},       {31'd0, e.err});
                checkOutput(k, "stall_cycles", stallOf(k),             e.stallCnt);
                checkOutput(k, "flush_count",  flushOf(k),             e.flushCnt);
            end
        end
    end

    // Watchdog so a broken run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mdlRem[k] = 0; mdlErr[k] = 0; mdlStall[k] = 0; mdlFlush[k] = 0;
        end
        @(posedge clk);

        // reset held with random inputs, then quiet cycles
        repeat (3) applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // branch bubble holding a redirect, then the redirect goes through
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // mult/div issue followed by HI/LO accesses
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (6) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // illegal restart two cycles after issue
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // reset in the middle of a long busy period
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // long load-use stall to wrap the narrow counter
        repeat (17) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // random traffic with occasional resets
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 9) == 0));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput(k, "pending_predictions", expQ[k].size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
